// File: rtl/bus_pkg.sv
// Shared types and defaults for the memory bus arbiter slice.
package bus_pkg;

    localparam int unsigned BUS_ADDR_W = 14;
    localparam int unsigned BUS_DATA_W = 10;

    typedef logic [BUS_ADDR_W-1:0] addr_t;
    typedef logic [BUS_DATA_W-1:0] data_t;

    typedef enum logic [1:0] {IDLE, WAIT, GRANT, DATA} state_t;

    function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
        return (cur + 1) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping.
module rr_arbiter #(
    parameter  int unsigned N_REQ = 2,
    localparam int unsigned IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_valid
);

    logic [IW-1:0] w_idx;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_idx = IW'((32'(i_ptr) + k) % N_REQ);
            if (!o_valid && i_req[w_idx]) begin
                o_valid         = 1'b1;
                o_idx           = w_idx;
                o_onehot[w_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Memory bus slave: round-robin arbitration, wait states, one-beat access to the
// local memory array with read data driven onto a shared tri-state bus.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter  int unsigned N_REQ       = 2,
    parameter  int unsigned ADDR_W      = BUS_ADDR_W,
    parameter  int unsigned DATA_W      = BUS_DATA_W,
    parameter  int unsigned DEPTH       = 16384,
    parameter  int unsigned WAIT_CYCLES = 3,
    parameter  string       INIT_FILE   = "",
    localparam int unsigned OW          = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    input  logic [N_REQ-1:0]          we,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    output logic [N_REQ-1:0]          grant,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [OW-1:0]             owner
);

    localparam int unsigned MW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    state_t             r_state;
    logic [N_REQ-1:0]   r_grant;
    logic [OW-1:0]      r_owner;
    logic [OW-1:0]      r_rr;
    logic [CW-1:0]      r_wcnt;
    logic [DATA_W-1:0]  r_rdata;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic [N_REQ-1:0]   w_win_oh;
    logic [OW-1:0]      w_win_idx;
    logic               w_win_valid;
    logic [N_REQ-1:0]   w_owner_oh;
    logic [ADDR_W-1:0]  w_addr;
    logic               w_we;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_in_range;
    logic [MW-1:0]      w_midx;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .i_req    (req),
        .i_ptr    (r_rr),
        .o_onehot (w_win_oh),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    assign w_owner_oh = N_REQ'(1) << r_owner;
    assign w_addr     = addr[r_owner*ADDR_W +: ADDR_W];
    assign w_we       = we[r_owner];
    assign w_wdata    = wdata[r_owner*DATA_W +: DATA_W];
    assign w_in_range = 32'(w_addr) < DEPTH;
    assign w_midx     = w_addr[MW-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_owner <= '0;
            r_rr    <= '0;
            r_wcnt  <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_owner <= w_win_idx;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= GRANT;
                            r_grant <= w_win_oh;
                        end else begin
                            r_state <= WAIT;
                            r_wcnt  <= CW'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    // A dropped request abandons the slot without moving the rr pointer.
                    if (!req[r_owner]) begin
                        r_state <= IDLE;
                    end else if (r_wcnt == '0) begin
                        r_state <= GRANT;
                        r_grant <= w_owner_oh;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                GRANT: begin
                    r_state <= DATA;
                    r_rdata <= w_we ? w_wdata : (w_in_range ? r_mem[w_midx] : '0);
                end
                DATA: begin
                    r_state <= IDLE;
                    r_grant <= '0;
                    r_rr    <= OW'(rr_next(32'(r_owner), N_REQ));
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == GRANT && w_we && w_in_range) begin
            r_mem[w_midx] <= w_wdata;
        end
    end

    assign rdata = (r_state == DATA) ? r_rdata : 'z;
    assign grant = r_grant;
    assign busy  = (r_state != IDLE);
    assign owner = r_owner;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench: a WAIT_CYCLES=3 instance with a short memory and a WAIT_CYCLES=0 instance.
module tb_mem_bus_arbiter;

    localparam int AW = 14;
    localparam int DW = 10;
    localparam int WA = 3;
    localparam logic [31:0] ZB = 32'h3FF;

    logic           clk;
    logic           rst;

    logic [1:0]     req_a, we_a, grant_a;
    logic [27:0]    addr_a;
    logic [19:0]    wdata_a;
    logic           busy_a;
    logic [0:0]     owner_a;
    // Weak pull-up: an undriven bus reads all-ones.
    tri1  [DW-1:0]  rdata_a;

    logic [1:0]     req_b, we_b, grant_b;
    logic [27:0]    addr_b;
    logic [19:0]    wdata_b;
    logic           busy_b;
    logic [0:0]     owner_b;
    tri1  [DW-1:0]  rdata_b;

    int n_checks = 0;
    int n_errors = 0;

    mem_bus_arbiter #(.DEPTH(16000), .WAIT_CYCLES(3)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .addr(addr_a), .we(we_a), .wdata(wdata_a),
        .grant(grant_a), .rdata(rdata_a), .busy(busy_a), .owner(owner_a)
    );

    mem_bus_arbiter #(.WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .addr(addr_b), .we(we_b), .wdata(wdata_b),
        .grant(grant_b), .rdata(rdata_b), .busy(busy_b), .owner(owner_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full beat on instance A; exp_rd < 0 skips the data check.
    task automatic xfer_a(input int p, input int a, input bit w, input int d,
                          input int exp_rd, input bit hold);
        req_a[p] = 1'b1;
        addr_a[p*AW +: AW] = AW'(a);
        we_a[p] = w;
        wdata_a[p*DW +: DW] = DW'(d);
        tick();
        chk("arb_busy", busy_a, 1);
        chk("arb_owner", owner_a, p);
        chk("wait_grant", grant_a, 0);
        chk("wait_rdata_z", rdata_a, ZB);
        repeat (WA - 1) begin
            tick();
            chk("wait_grant", grant_a, 0);
        end
        tick();
        chk("grant_rise", grant_a, 1 << p);
        chk("grant_rdata_z", rdata_a, ZB);
        if (!hold) req_a[p] = 1'b0;
        tick();
        chk("data_grant", grant_a, 1 << p);
        if (exp_rd >= 0) chk("data_rdata", rdata_a, exp_rd);
        tick();
        chk("idle_grant", grant_a, 0);
        chk("idle_busy", busy_a, 0);
        chk("idle_rdata_z", rdata_a, ZB);
        we_a[p] = 1'b0;
    endtask

    task automatic xfer_b(input int p, input int a, input bit w, input int d, input int exp_rd);
        req_b[p] = 1'b1;
        addr_b[p*AW +: AW] = AW'(a);
        we_b[p] = w;
        wdata_b[p*DW +: DW] = DW'(d);
        tick();
        chk("b_grant_rise", grant_b, 1 << p);
        chk("b_owner", owner_b, p);
        chk("b_grant_rdata_z", rdata_b, ZB);
        req_b[p] = 1'b0;
        tick();
        chk("b_data_grant", grant_b, 1 << p);
        chk("b_data_rdata", rdata_b, exp_rd);
        tick();
        chk("b_idle_grant", grant_b, 0);
        chk("b_idle_rdata_z", rdata_b, ZB);
        we_b[p] = 1'b0;
    endtask

    task automatic abort_a(input int p);
        req_a[p] = 1'b1;
        addr_a[p*AW +: AW] = AW'(5);
        we_a[p] = 1'b0;
        tick();
        chk("abort_busy", busy_a, 1);
        chk("abort_owner", owner_a, p);
        req_a[p] = 1'b0;
        tick();
        chk("abort_idle", busy_a, 0);
        chk("abort_grant", grant_a, 0);
        tick();
        chk("abort_grant2", grant_a, 0);
        chk("abort_rdata_z", rdata_a, ZB);
    endtask

    initial begin
        rst = 1'b0;
        req_a = '0; we_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; we_b = '0; addr_b = '0; wdata_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_owner", owner_a, 0);
        chk("rst_rdata_z", rdata_a, ZB);
        chk("rst_b_rdata_z", rdata_b, ZB);
        rst = 1'b1;
        tick();

        // preload mem[5]=7, then DMA read of it
        xfer_a(0, 5, 1'b1, 7, 7, 1'b0);
        xfer_a(1, 5, 1'b0, 0, 7, 1'b0);

        // CPU write then DMA read-back
        xfer_a(0, 100, 1'b1, 10'h3FF, 10'h3FF, 1'b0);
        xfer_a(1, 100, 1'b0, 0, 10'h3FF, 1'b0);

        // address range edge with DEPTH=16000
        xfer_a(0, 15999, 1'b1, 10'h0AA, 10'h0AA, 1'b0);
        xfer_a(0, 16100, 1'b1, 10'h155, -1, 1'b0);
        xfer_a(1, 16100, 1'b0, 0, 0, 1'b0);
        xfer_a(1, 15999, 1'b0, 0, 10'h0AA, 1'b0);

        // reset during DATA of a read
        req_a[1] = 1'b1;
        addr_a[AW +: AW] = AW'(5);
        we_a[1] = 1'b0;
        repeat (WA + 2) tick();
        chk("pre_rst_rdata", rdata_a, 7);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_grant", grant_a, 0);
        chk("async_rst_busy", busy_a, 0);
        chk("async_rst_rdata_z", rdata_a, ZB);
        req_a = '0;
        tick();
        rst = 1'b1;
        tick();

        // reset during GRANT of a write: the write must not land
        req_a[0] = 1'b1;
        addr_a[0 +: AW] = AW'(5);
        we_a[0] = 1'b1;
        wdata_a[0 +: DW] = DW'(10'h111);
        repeat (WA + 1) tick();
        chk("pre_rst_grant", grant_a, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_grant_w", grant_a, 0);
        req_a = '0;
        we_a = '0;
        tick();
        rst = 1'b1;
        tick();
        xfer_a(1, 5, 1'b0, 0, 7, 1'b0);

        // DMA abort, normal DMA beat, then CPU abort (pointer must stay at port 0)
        abort_a(1);
        xfer_a(1, 100, 1'b0, 0, 10'h3FF, 1'b0);
        abort_a(0);

        // both requesters held: strict alternation starting with CPU
        req_a = 2'b11;
        addr_a[0 +: AW]  = AW'(5);
        addr_a[AW +: AW] = AW'(100);
        we_a = '0;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) xfer_a(0, 5, 1'b0, 0, 7, 1'b1);
            else            xfer_a(1, 100, 1'b0, 0, 10'h3FF, 1'b1);
        end
        req_a = '0;

        // zero-wait instance, top address
        xfer_b(0, 16383, 1'b1, 10'h2A5, 10'h2A5);
        xfer_b(1, 16383, 1'b0, 0, 10'h2A5);
        xfer_b(1, 0, 1'b1, 10'h01C, 10'h01C);
        xfer_b(0, 16383, 1'b0, 0, 10'h2A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
